// File: rtl/book_pkg.sv
// Shared types and default widths for the book update path.
package book_pkg;

    localparam int DEF_PRICE_W = 48;
    localparam int DEF_QTY_W   = 32;

    // One book update as seen by a sorted price cache (default widths).
    typedef struct packed {
        logic                   is_ask;
        logic [DEF_PRICE_W-1:0] price;
        logic [DEF_QTY_W-1:0]   qty;
    } book_upd_t;

    // Quiesce FSM: RUN grants freely, DRAIN lets the issue stage empty,
    // HALTED reports a quiet book to software.
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last winner and wraps.
// The pointer moves to the winner only on a grant, so requester 0 has first
// priority after reset (pointer resets to N-1).
module rr_arbiter #(
    parameter int N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [N-1:0]     req_i,
    input  logic             en_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] grant_idx_o
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;
    logic             found;

    // Rotating priority search; one extra bit in sum handles the wrap for any N.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        sum         = '0;
        cand        = '0;
        for (int k = 1; k <= N; k++) begin
            sum = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(N)) begin
                sum = sum - (IDX_W+1)'(N);
            end
            cand = sum[IDX_W-1:0];
            if (en_i && !found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                grant_idx_o   = cand;
            end
        end
        ptr_d = found ? grant_idx_o : ptr_q;
    end

    // Pointer register: holds the index of the last winner.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q <= IDX_W'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/book_update_arbiter.sv
// Book update arbiter: picks one feed-handler update per cycle round-robin,
// registers it into a single-cycle strobe toward the bid or ask cache, offers
// a halt/drain handshake, and watches both caches' best levels for
// top-of-book changes and crossed-book errors.
//
// Handshake: requester i transfers in a cycle where req_valid[i] and
// req_ready[i] are both 1; req_ready is one-hot or zero and depends only on
// req_valid, the round-robin pointer, the FSM state and halt_req. The caches
// always accept, so strobes never stall.
module book_update_arbiter
    import book_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PRICE_W = DEF_PRICE_W,
    parameter int QTY_W   = DEF_QTY_W,
    parameter int CNT_W   = 32,
    localparam int SRC_W  = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ-1:0]         req_is_ask,
    input  logic [NUM_REQ*PRICE_W-1:0] req_price,
    input  logic [NUM_REQ*QTY_W-1:0]   req_qty,
    input  logic                       halt_req,
    output logic                       halted,
    output logic                       bid_upd_valid,
    output logic                       ask_upd_valid,
    output logic [PRICE_W-1:0]         upd_price,
    output logic [QTY_W-1:0]           upd_qty,
    output logic [SRC_W-1:0]           upd_src,
    input  logic [PRICE_W-1:0]         bid_best_price,
    input  logic                       bid_best_valid,
    input  logic [PRICE_W-1:0]         ask_best_price,
    input  logic                       ask_best_valid,
    output logic                       bid_top_chg,
    output logic                       ask_top_chg,
    output logic                       crossed,
    output logic                       crossed_err,
    input  logic                       clr_err,
    output logic [CNT_W-1:0]           upd_count,
    output logic [1:0]                 dbg_state
);

    arb_state_e         state_q, state_d;
    logic               grant_en;
    logic [NUM_REQ-1:0] grant;
    logic [SRC_W-1:0]   grant_idx;
    logic               xfer;

    logic               strobe_q, strobe_d;
    logic               is_ask_q, is_ask_d;
    logic [PRICE_W-1:0] price_q, price_d;
    logic [QTY_W-1:0]   qty_q, qty_d;
    logic [SRC_W-1:0]   src_q, src_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    // Grants only while running and not asked to halt, so the cycle halt_req
    // first rises already blocks new work.
    assign grant_en = (state_q == RUN) && !halt_req;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .clk         (clk),
        .rstn        (rstn),
        .req_i       (req_valid),
        .en_i        (grant_en),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    assign req_ready = grant;
    assign xfer      = |(req_valid & req_ready);

    // Issue stage next-state: capture the winner's payload; the count tracks
    // strobes, so it already includes the strobe being presented.
    always_comb begin
        strobe_d = xfer;
        is_ask_d = is_ask_q;
        price_d  = price_q;
        qty_d    = qty_q;
        src_d    = src_q;
        cnt_d    = cnt_q;
        if (xfer) begin
            src_d = grant_idx;
            cnt_d = cnt_q + CNT_W'(1);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i]) begin
                    is_ask_d = req_is_ask[i];
                    price_d  = req_price[i*PRICE_W +: PRICE_W];
                    qty_d    = req_qty[i*QTY_W +: QTY_W];
                end
            end
        end
    end

    // Issue stage registers; reset drops any pending strobe.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            strobe_q <= 1'b0;
            is_ask_q <= 1'b0;
            price_q  <= '0;
            qty_q    <= '0;
            src_q    <= '0;
            cnt_q    <= '0;
        end else begin
            strobe_q <= strobe_d;
            is_ask_q <= is_ask_d;
            price_q  <= price_d;
            qty_q    <= qty_d;
            src_q    <= src_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bid_upd_valid = strobe_q && !is_ask_q;
    assign ask_upd_valid = strobe_q && is_ask_q;
    assign upd_price     = price_q;
    assign upd_qty       = qty_q;
    assign upd_src       = src_q;
    assign upd_count     = cnt_q;

    // Quiesce FSM next state: DRAIN waits for the issue stage to empty.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (halt_req) state_d = DRAIN;
            end
            DRAIN: begin
                if (!halt_req)     state_d = RUN;
                else if (!strobe_q) state_d = HALTED;
            end
            HALTED: begin
                if (!halt_req) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // Quiesce FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign halted    = (state_q == HALTED);
    assign dbg_state = state_q;

    // Top-of-book monitor, one copy per side (0 = bid, 1 = ask).
    logic [1:0]              cur_v;
    logic [1:0][PRICE_W-1:0] cur_p;
    logic [1:0]              top_chg;

    assign cur_v = {ask_best_valid, bid_best_valid};
    assign cur_p = {ask_best_price, bid_best_price};

    for (genvar s = 0; s < 2; s++) begin : g_top
        logic               prev_v_q;
        logic [PRICE_W-1:0] prev_p_q;
        logic               chg_q;
        logic               chg_d;

        // A change is a validity flip, or a price move between two valid samples.
        always_comb begin
            chg_d = (cur_v[s] != prev_v_q) ||
                    (cur_v[s] && prev_v_q && (cur_p[s] != prev_p_q));
        end

        // Sample the best level every cycle and register the change pulse.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                prev_v_q <= 1'b0;
                prev_p_q <= '0;
                chg_q    <= 1'b0;
            end else begin
                prev_v_q <= cur_v[s];
                prev_p_q <= cur_p[s];
                chg_q    <= chg_d;
            end
        end

        assign top_chg[s] = chg_q;
    end

    assign bid_top_chg = top_chg[0];
    assign ask_top_chg = top_chg[1];

    // Crossed book: both sides valid and the best bid reaches the best ask.
    assign crossed = bid_best_valid && ask_best_valid &&
                     (bid_best_price >= ask_best_price);

    // Sticky error next state: a live cross beats a simultaneous clear.
    always_comb begin
        err_d = err_q;
        if (crossed)      err_d = 1'b1;
        else if (clr_err) err_d = 1'b0;
    end

    // Sticky error register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign crossed_err = err_q;

endmodule

// File: tb/tb_book_update_arbiter.sv
// Directed bench for book_update_arbiter: a per-cycle vector table for the
// grant / issue / halt behaviour plus hand-written sequences for reset,
// the top-of-book monitor and the crossed-book error.
module tb_book_update_arbiter;

    localparam int NUM_REQ = 4;
    localparam int PRICE_W = 48;
    localparam int QTY_W   = 32;
    localparam int CNT_W   = 4;
    localparam int SRC_W   = 2;

    logic                       clk;
    logic                       rstn;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ-1:0]         req_is_ask;
    logic [NUM_REQ*PRICE_W-1:0] req_price;
    logic [NUM_REQ*QTY_W-1:0]   req_qty;
    logic                       halt_req;
    logic                       halted;
    logic                       bid_upd_valid;
    logic                       ask_upd_valid;
    logic [PRICE_W-1:0]         upd_price;
    logic [QTY_W-1:0]           upd_qty;
    logic [SRC_W-1:0]           upd_src;
    logic [PRICE_W-1:0]         bid_best_price;
    logic                       bid_best_valid;
    logic [PRICE_W-1:0]         ask_best_price;
    logic                       ask_best_valid;
    logic                       bid_top_chg;
    logic                       ask_top_chg;
    logic                       crossed;
    logic                       crossed_err;
    logic                       clr_err;
    logic [CNT_W-1:0]           upd_count;
    logic [1:0]                 dbg_state;

    book_update_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PRICE_W (PRICE_W),
        .QTY_W   (QTY_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_is_ask     (req_is_ask),
        .req_price      (req_price),
        .req_qty        (req_qty),
        .halt_req       (halt_req),
        .halted         (halted),
        .bid_upd_valid  (bid_upd_valid),
        .ask_upd_valid  (ask_upd_valid),
        .upd_price      (upd_price),
        .upd_qty        (upd_qty),
        .upd_src        (upd_src),
        .bid_best_price (bid_best_price),
        .bid_best_valid (bid_best_valid),
        .ask_best_price (ask_best_price),
        .ask_best_valid (ask_best_valid),
        .bid_top_chg    (bid_top_chg),
        .ask_top_chg    (ask_top_chg),
        .crossed        (crossed),
        .crossed_err    (crossed_err),
        .clr_err        (clr_err),
        .upd_count      (upd_count),
        .dbg_state      (dbg_state)
    );

    // Clock and counters.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [PRICE_W-1:0] p, input logic [QTY_W-1:0] q);
        req_price[i*PRICE_W +: PRICE_W] = p;
        req_qty[i*QTY_W +: QTY_W]       = q;
    endtask

    // Per-cycle vector: inputs, then what must be seen in that cycle.
    // Strobe expectations come from the grant one row earlier.
    typedef struct {
        logic [3:0] valid;
        logic [3:0] is_ask;
        logic       halt;
        logic [3:0] exp_ready;
        logic       exp_bid;
        logic       exp_ask;
        int         exp_src;
        logic       exp_halted;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [3:0] v, input logic [3:0] a, input logic h,
                       input logic [3:0] r, input logic b, input logic k,
                       input int s, input logic hd);
        vec_t e;
        e.valid = v; e.is_ask = a; e.halt = h; e.exp_ready = r;
        e.exp_bid = b; e.exp_ask = k; e.exp_src = s; e.exp_halted = hd;
        tbl.push_back(e);
    endtask

    // Monitor row: drive best levels, check crossed now and the registered
    // outputs produced by the previous row's inputs.
    task automatic mcyc(input logic bv, input int bp, input logic av, input int ap,
                        input logic clr, input logic e_cr, input logic e_err,
                        input logic e_bc, input logic e_ac);
        bid_best_valid = bv; bid_best_price = PRICE_W'(bp);
        ask_best_valid = av; ask_best_price = PRICE_W'(ap);
        clr_err = clr;
        #1;
        chk("crossed", 64'(crossed), 64'(e_cr));
        chk("crossed_err", 64'(crossed_err), 64'(e_err));
        chk("bid_top_chg", 64'(bid_top_chg), 64'(e_bc));
        chk("ask_top_chg", 64'(ask_top_chg), 64'(e_ac));
        @(posedge clk); #1;
    endtask

    logic [CNT_W-1:0] exp_cnt;

    initial begin
        rstn = 1'b0; req_valid = '0; req_is_ask = '0; req_price = '0; req_qty = '0;
        halt_req = 1'b0; clr_err = 1'b0;
        bid_best_price = '0; bid_best_valid = 1'b0;
        ask_best_price = '0; ask_best_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        #1;
        // Reset state.
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk("rst_bid_v", 64'(bid_upd_valid), 64'h0);
        chk("rst_ask_v", 64'(ask_upd_valid), 64'h0);
        chk("rst_price", 64'(upd_price), 64'h0);
        chk("rst_qty", 64'(upd_qty), 64'h0);
        chk("rst_src", 64'(upd_src), 64'h0);
        chk("rst_count", 64'(upd_count), 64'h0);
        chk("rst_halted", 64'(halted), 64'h0);
        chk("rst_err", 64'(crossed_err), 64'h0);
        chk("rst_tops", 64'({bid_top_chg, ask_top_chg}), 64'h0);

        // First transaction: req0 bid 100/5, then req1 ask 200/6.
        set_req(0, 100, 5);
        set_req(1, 200, 6);
        req_is_ask = 4'b0010;
        req_valid  = 4'b0001;
        #1 chk("first_ready", 64'(req_ready), 64'h1);
        @(posedge clk); #1;
        req_valid = 4'b0010;
        #1;
        chk("first_bid_v", 64'(bid_upd_valid), 64'h1);
        chk("first_ask_v", 64'(ask_upd_valid), 64'h0);
        chk("first_price", 64'(upd_price), 64'd100);
        chk("first_qty", 64'(upd_qty), 64'd5);
        chk("first_src", 64'(upd_src), 64'd0);
        chk("first_count", 64'(upd_count), 64'd1);
        chk("second_ready", 64'(req_ready), 64'h2);
        @(posedge clk); #1;
        req_valid = 4'b0000;
        #1;
        chk("second_ask_v", 64'(ask_upd_valid), 64'h1);
        chk("second_src", 64'(upd_src), 64'd1);
        chk("second_count", 64'(upd_count), 64'd2);
        // Reset with a strobe on the outputs: it must vanish and stay gone.
        rstn = 1'b0;
        #1;
        chk("mid_rst_ask_v", 64'(ask_upd_valid), 64'h0);
        chk("mid_rst_count", 64'(upd_count), 64'h0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_strobe", 64'({bid_upd_valid, ask_upd_valid}), 64'h0);

        // Table: requester i carries price 1000+i, qty 10+i.
        for (int i = 0; i < NUM_REQ; i++) set_req(i, PRICE_W'(1000 + i), QTY_W'(10 + i));
        // All four valid: grants 0,1,2,3,0,1,2,3 and eight back-to-back strobes.
        add(4'hF, 4'h0, 0, 4'h1, 0, 0, 0, 0);
        add(4'hF, 4'h0, 0, 4'h2, 1, 0, 0, 0);
        add(4'hF, 4'h0, 0, 4'h4, 1, 0, 1, 0);
        add(4'hF, 4'h0, 0, 4'h8, 1, 0, 2, 0);
        add(4'hF, 4'h0, 0, 4'h1, 1, 0, 3, 0);
        add(4'hF, 4'h0, 0, 4'h2, 1, 0, 0, 0);
        add(4'hF, 4'h0, 0, 4'h4, 1, 0, 1, 0);
        add(4'hF, 4'h0, 0, 4'h8, 1, 0, 2, 0);
        add(4'h0, 4'h0, 0, 4'h0, 1, 0, 3, 0);
        add(4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 0);
        // Only req2 (bid) and req3 (ask): alternation, ask strobe on req3 only.
        add(4'hC, 4'h8, 0, 4'h4, 0, 0, 0, 0);
        add(4'hC, 4'h8, 0, 4'h8, 1, 0, 2, 0);
        add(4'hC, 4'h8, 0, 4'h4, 0, 1, 3, 0);
        add(4'hC, 4'h8, 0, 4'h8, 1, 0, 2, 0);
        add(4'h0, 4'h8, 0, 4'h0, 0, 1, 3, 0);
        add(4'h0, 4'h8, 0, 4'h0, 0, 0, 0, 0);
        // Halt in the cycle after a grant: last strobe, DRAIN, then HALTED.
        add(4'h1, 4'h0, 0, 4'h1, 0, 0, 0, 0);
        add(4'h1, 4'h0, 1, 4'h0, 1, 0, 0, 0);
        add(4'h1, 4'h0, 1, 4'h0, 0, 0, 0, 0);
        add(4'h1, 4'h0, 1, 4'h0, 0, 0, 0, 1);
        // Release: one HALTED cycle, then grants resume after pointer 0.
        add(4'h3, 4'h0, 0, 4'h0, 0, 0, 0, 1);
        add(4'h3, 4'h0, 0, 4'h2, 0, 0, 0, 0);
        add(4'h0, 4'h0, 0, 4'h0, 1, 0, 1, 0);
        // Short halt pulse: DRAIN goes back to RUN without halting.
        add(4'h0, 4'h0, 1, 4'h0, 0, 0, 0, 0);
        add(4'h4, 4'h0, 0, 4'h0, 0, 0, 0, 0);
        add(4'h4, 4'h0, 0, 4'h4, 0, 0, 0, 0);
        add(4'h0, 4'h0, 0, 4'h0, 1, 0, 2, 0);
        // Sixteenth strobe wraps the 4-bit counter to 0.
        add(4'h1, 4'h0, 0, 4'h1, 0, 0, 0, 0);
        add(4'h0, 4'h0, 0, 4'h0, 1, 0, 0, 0);
        add(4'h0, 4'h0, 0, 4'h0, 0, 0, 0, 0);

        exp_cnt = '0;
        foreach (tbl[r]) begin
            req_valid  = tbl[r].valid;
            req_is_ask = tbl[r].is_ask;
            halt_req   = tbl[r].halt;
            if (tbl[r].exp_bid || tbl[r].exp_ask) exp_cnt = exp_cnt + CNT_W'(1);
            #1;
            chk($sformatf("v%0d_ready", r), 64'(req_ready), 64'(tbl[r].exp_ready));
            chk($sformatf("v%0d_bid_v", r), 64'(bid_upd_valid), 64'(tbl[r].exp_bid));
            chk($sformatf("v%0d_ask_v", r), 64'(ask_upd_valid), 64'(tbl[r].exp_ask));
            chk($sformatf("v%0d_halted", r), 64'(halted), 64'(tbl[r].exp_halted));
            chk($sformatf("v%0d_count", r), 64'(upd_count), 64'(exp_cnt));
            if (tbl[r].exp_bid || tbl[r].exp_ask) begin
                chk($sformatf("v%0d_src", r), 64'(upd_src), 64'(tbl[r].exp_src));
                chk($sformatf("v%0d_price", r), 64'(upd_price), 64'(1000 + tbl[r].exp_src));
                chk($sformatf("v%0d_qty", r), 64'(upd_qty), 64'(10 + tbl[r].exp_src));
            end
            @(posedge clk); #1;
        end
        req_valid = '0; halt_req = 1'b0;

        // Crossed book and sticky error.
        mcyc(0,   0, 0,   0, 0, 0, 0, 0, 0);
        mcyc(1, 101, 1, 100, 0, 1, 0, 0, 0);
        mcyc(1, 101, 1, 100, 1, 1, 1, 1, 1);  // clear while crossed
        mcyc(1, 101, 1, 102, 0, 0, 1, 0, 0);  // set won over clear
        mcyc(1, 101, 1, 102, 1, 0, 1, 0, 1);  // still sticky, now clear
        // Top-of-book change pulses on the bid side.
        mcyc(0,   0, 1, 102, 0, 0, 0, 0, 0);
        mcyc(1,  99, 1, 102, 0, 0, 0, 1, 0);
        mcyc(1,  99, 1, 102, 0, 0, 0, 1, 0);
        mcyc(1,  98, 1, 102, 0, 0, 0, 0, 0);
        mcyc(0,   0, 1, 102, 0, 0, 0, 1, 0);
        mcyc(0,   7, 1, 102, 0, 0, 0, 1, 0);
        mcyc(0,   7, 0,   0, 0, 0, 0, 0, 0);  // invalid 0 -> invalid 7: quiet
        // Equal prices count as crossed; one-sided validity does not.
        mcyc(1,  50, 1,  50, 0, 1, 0, 0, 1);
        mcyc(1,  50, 0,  50, 1, 0, 1, 1, 1);
        mcyc(0,   0, 0,   0, 0, 0, 0, 0, 1);
        mcyc(0,   0, 0,   0, 0, 0, 0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/book_update_arbiter.md
Name: book_update_arbiter

Overview:
- Sequences book updates from NUM_REQ feed-handler requesters into one bid and one ask sorted price cache, at one update per cycle.
- Arbitration is round-robin with a registered issue stage.
- Provides a halt/drain handshake so software can quiesce the book.
- Monitors both caches' best-level outputs for top-of-book changes and crossed-book errors.

Parameters:
- NUM_REQ, 4, number of update requesters (2..16).
- PRICE_W, 48, price width.
- QTY_W, 32, quantity width.
- CNT_W, 32, width of issued-update counter.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester update valid.
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero).
- req_is_ask  in  NUM_REQ  side per requester (1 = ask).
- req_price  in  NUM_REQ*PRICE_W  packed prices; requester i at [i*PRICE_W +: PRICE_W].
- req_qty  in  NUM_REQ*QTY_W  packed quantities; qty 0 = delete level.
- halt_req  in  1  request quiesce.
- halted  out  1  no update in flight, no grants.
- bid_upd_valid  out  1  update strobe to bid cache.
- ask_upd_valid  out  1  update strobe to ask cache.
- upd_price  out  PRICE_W  price to both caches.
- upd_qty  out  QTY_W  qty to both caches.
- upd_src  out  $clog2(NUM_REQ)  index of requester that produced the current strobe.
- bid_best_price  in  PRICE_W  from bid cache.
- bid_best_valid  in  1  from bid cache.
- ask_best_price  in  PRICE_W  from ask cache.
- ask_best_valid  in  1  from ask cache.
- bid_top_chg  out  1  pulse: bid best changed.
- ask_top_chg  out  1  pulse: ask best changed.
- crossed  out  1  combinational: both valid and bid_best_price >= ask_best_price.
- crossed_err  out  1  sticky crossed flag.
- clr_err  in  1  clears crossed_err.
- upd_count  out  CNT_W  updates issued, wrapping.

Behaviour:
- Reset values:
  - All outputs 0; crossed_err 0; upd_count 0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
  - FSM in RUN.
  - Previous-best registers invalid, price 0.
- Grant:
  - Only when FSM=RUN and halt_req=0.
  - Search begins at pointer+1 and wraps modulo NUM_REQ; first requester with req_valid=1 wins.
  - req_ready[winner]=1 in the same cycle (combinational from req_valid, pointer, state). Transfer = valid & ready.
  - Pointer := winner on grant only; otherwise held.
- Issue stage:
  - Transfer in cycle N gives exactly one of bid_upd_valid/ask_upd_valid high in cycle N+1 (selected by req_is_ask), with upd_price/upd_qty/upd_src registered.
  - Strobes are single-cycle; the caches always accept, so the stage never stalls.
  - Back-to-back grants give back-to-back strobes (throughput 1/cycle).
  - upd_price/upd_qty/upd_src hold their last value when no strobe.
- upd_count increments on each strobe cycle; wraps 2^CNT_W-1 -> 0.
- FSM:
  - RUN -> DRAIN when halt_req=1.
  - DRAIN -> HALTED when the issue stage holds no strobe, i.e. the cycle after the last strobe.
  - DRAIN -> RUN if halt_req drops before HALTED.
  - HALTED -> RUN when halt_req=0.
  - halted=1 only in HALTED.
  - A grant is impossible in any cycle with halt_req=1, including the cycle halt_req first rises.
- Top monitor:
  - Every cycle, register {bid_best_valid, bid_best_price} and the same for ask.
  - bid_top_chg=1 (registered, one cycle after the input change) when the current input pair differs from the registered previous pair.
  - Invalid->invalid with a differing price is not a change: compare price only when both samples are valid.
  - Same rule for ask.
- crossed_err:
  - Set on the clock edge where crossed=1.
  - Cleared by clr_err when crossed=0.
  - If clr_err and crossed are high simultaneously, set wins.
- Reset mid-operation: any pending strobe is dropped; no strobe is emitted after rstn deasserts without a new grant.

Decomposition:
- Package book_pkg:
  - PRICE_W and QTY_W defaults.
  - book_upd_t packed struct {is_ask, price, qty}.
  - arb_state_e enum {RUN, DRAIN, HALTED}.
- Sub-module rr_arbiter: parameter N, inputs req and pointer-advance enable, outputs one-hot grant and grant index; owns the pointer register.
- Top monitor stays inline, instantiated twice via a generate or as a small repeated block.

Test Plan:
- Reset, then req0 valid (bid, price 100, qty 5) -> req_ready[0] same cycle; next cycle bid_upd_valid=1, upd_price=100, upd_qty=5, upd_src=0, ask_upd_valid=0; upd_count=1.
- All 4 requesters held valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3; strobes on 8 consecutive cycles; no requester starved.
- Only req2 and req3 valid, req3 ask -> alternating 2,3,2,3; ask_upd_valid only on req3 strobes.
- halt_req raised in the cycle after a grant -> no further req_ready; one final strobe; halted=1 the next cycle. halt_req dropped -> grants resume with the pointer unchanged.
- Drive bid_best 101/valid with ask_best 100/valid -> crossed=1 immediately, crossed_err=1 next edge. clr_err while still crossed -> stays 1. Ask moved to 102, then clr_err -> crossed_err=0.
- bid_best invalid, then valid at 99 -> bid_top_chg pulses one cycle. Price held at 99 -> no pulse. Changed to 98 -> pulse. Invalid with price 0 -> 7 -> no pulse.
